lsq_mem_responder: RTL and testbench

//  Memory-side responder for the load-store queue issue port. Accepts one issued load/store
//  per cycle into a small request FIFO, performs word/byte accesses on an internal data memory

---
 rtl/lsq_mem_responder_if.sv | 38 +++
 rtl/lsq_mem_responder.sv | 183 ++++++++++++++++++
 tb/tb_lsq_mem_responder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lsq_mem_responder_if.sv
// LSQ issue port / response bus between the load-store queue and the memory responder.
interface lsq_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic [5:0]  req_rob;
    logic [5:0]  req_dest;
    logic [31:0] req_addr;
    logic        req_is_store;
    logic        req_byte;
    logic [31:0] req_wdata;
    logic        req_fwd;
    logic [31:0] req_fwd_data;

    logic        resp_valid;
    logic [31:0] resp_pc;
    logic [5:0]  resp_rob;
    logic [5:0]  resp_dest;
    logic [31:0] resp_data;
    logic        resp_is_store;
    logic        resp_misaligned;

    // LSQ side: issues requests, consumes responses
    modport master (
        output req_valid, req_pc, req_rob, req_dest, req_addr, req_is_store,
               req_byte, req_wdata, req_fwd, req_fwd_data,
        input  req_ready, resp_valid, resp_pc, resp_rob, resp_dest, resp_data,
               resp_is_store, resp_misaligned
    );

    // Memory responder side
    modport slave (
        input  req_valid, req_pc, req_rob, req_dest, req_addr, req_is_store,
               req_byte, req_wdata, req_fwd, req_fwd_data,
        output req_ready, resp_valid, resp_pc, resp_rob, resp_dest, resp_data,
               resp_is_store, resp_misaligned
    );
endinterface

// File: rtl/lsq_mem_responder.sv
// Memory-side responder for the LSQ issue port: request FIFO, fixed-latency
// word/byte data memory, one in-order response per accepted request.
module lsq_mem_responder #(
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MEM_WORDS  = 1024
) (
    input  logic                 clk,
    input  logic                 rstn,
    lsq_mem_responder_if.slave   bus
);
    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    // Queued request; data holds store data or forwarded load data
    typedef struct packed {
        logic [31:0]   pc;
        logic [5:0]    rob;
        logic [5:0]    dest;
        logic [AW+1:0] addr;
        logic          is_store;
        logic          is_byte;
        logic          fwd;
        logic [31:0]   data;
    } entry_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [5:0]  rob;
        logic [5:0]  dest;
        logic [31:0] data;
        logic        is_store;
        logic        misaligned;
    } resp_t;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    entry_t        fifo_q [FIFO_DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    entry_t        new_entry;
    entry_t        head;

    state_t        state;
    logic [CW-1:0] cnt;
    entry_t        cur;
    resp_t         resp_q;

    logic [31:0]   mem [MEM_WORDS];
    logic [AW-1:0] idx;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [31:0]   ld_data;
    logic [31:0]   wr_word;
    logic          mem_we;
    logic          unused_bits;

    // Response fields for a completed op; stores report zero dest/data
    function automatic resp_t mk_resp(entry_t e, logic [31:0] d);
        resp_t r;
        r            = '0;
        r.valid      = 1'b1;
        r.pc         = e.pc;
        r.rob        = e.rob;
        r.is_store   = e.is_store;
        r.misaligned = !e.is_byte && (e.addr[1:0] != 2'b00);
        if (!e.is_store) begin
            r.dest = e.dest;
            r.data = d;
        end
        return r;
    endfunction

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign push  = bus.req_valid && !full;
    assign pop   = ((state == S_IDLE) || (state == S_RESP)) && !empty;
    assign head  = fifo_q[rd_ptr[PW-1:0]];

    // Upper address bits wrap; the queued fwd flag only steers the pop decision
    assign unused_bits = ^{bus.req_addr[31:AW+2], cur.fwd};

    // Pack an incoming request; forwarding is meaningless for stores
    always_comb begin
        new_entry          = '0;
        new_entry.pc       = bus.req_pc;
        new_entry.rob      = bus.req_rob;
        new_entry.dest     = bus.req_dest;
        new_entry.addr     = bus.req_addr[AW+1:0];
        new_entry.is_store = bus.req_is_store;
        new_entry.is_byte  = bus.req_byte;
        new_entry.fwd      = bus.req_fwd && !bus.req_is_store;
        new_entry.data     = bus.req_is_store ? bus.req_wdata : bus.req_fwd_data;
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr[PW-1:0]] <= new_entry;
    end

    // FIFO write pointer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)     wr_ptr <= '0;
        else if (push) wr_ptr <= wr_ptr + 1'b1;
    end

    // FIFO read pointer, advanced when the FSM takes the head
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)    rd_ptr <= '0;
        else if (pop) rd_ptr <= rd_ptr + 1'b1;
    end

    assign idx     = cur.addr[AW+1:2];
    assign rd_word = mem[idx];
    assign rd_byte = rd_word[{cur.addr[1:0], 3'b000} +: 8];
    assign ld_data = cur.is_byte ? {{24{rd_byte[7]}}, rd_byte} : rd_word;
    assign mem_we  = (state == S_ACCESS) && (cnt == '0) && cur.is_store;

    // Store word: whole word, or read-merge of one byte lane
    always_comb begin
        wr_word = cur.data;
        if (cur.is_byte) begin
            wr_word = rd_word;
            wr_word[{cur.addr[1:0], 3'b000} +: 8] = cur.data[7:0];
        end
    end

    // Data memory write; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= wr_word;
    end

    // Access sequencer with registered response outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= S_IDLE;
            cnt    <= '0;
            cur    <= '0;
            resp_q <= '0;
        end else begin
            case (state)
                S_IDLE, S_RESP: begin
                    resp_q <= '0;
                    state  <= S_IDLE;
                    if (!empty) begin
                        cur <= head;
                        if (head.fwd) begin
                            state  <= S_RESP;
                            resp_q <= mk_resp(head, head.data);
                        end else begin
                            state <= S_ACCESS;
                            cnt   <= CW'(LATENCY - 1);
                        end
                    end
                end
                S_ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state  <= S_RESP;
                        resp_q <= mk_resp(cur, ld_data);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready       = !full;
    assign bus.resp_valid      = resp_q.valid;
    assign bus.resp_pc         = resp_q.pc;
    assign bus.resp_rob        = resp_q.rob;
    assign bus.resp_dest       = resp_q.dest;
    assign bus.resp_data       = resp_q.data;
    assign bus.resp_is_store   = resp_q.is_store;
    assign bus.resp_misaligned = resp_q.misaligned;
endmodule

// File: tb/tb_lsq_mem_responder.sv
// Directed bench for lsq_mem_responder (LATENCY=2, FIFO_DEPTH=4, MEM_WORDS=1024).
module tb_lsq_mem_responder;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   cyc  = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    lsq_mem_responder_if bus();

    lsq_mem_responder #(.LATENCY(2), .FIFO_DEPTH(4), .MEM_WORDS(1024)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic [5:0]  rob;
        logic [5:0]  dest;
        logic [31:0] data;
        logic        st;
        logic        mis;
    } rec_t;

    rec_t rq[$];
    rec_t mon;

    // Edge counter
    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.resp_valid === 1'b1) begin
            mon.cyc  = cyc;
            mon.pc   = bus.resp_pc;
            mon.rob  = bus.resp_rob;
            mon.dest = bus.resp_dest;
            mon.data = bus.resp_data;
            mon.st   = bus.resp_is_store;
            mon.mis  = bus.resp_misaligned;
            rq.push_back(mon);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_req();
        bus.req_valid    = 1'b0;
        bus.req_pc       = '0;
        bus.req_rob      = '0;
        bus.req_dest     = '0;
        bus.req_addr     = '0;
        bus.req_is_store = 1'b0;
        bus.req_byte     = 1'b0;
        bus.req_wdata    = '0;
        bus.req_fwd      = 1'b0;
        bus.req_fwd_data = '0;
    endtask

    // Present one request and hold it until accepted; acc = edge count of acceptance
    task automatic send(input logic [5:0] rob, input logic [31:0] addr, input logic st,
                        input logic byt, input logic [31:0] wd, input logic fwd,
                        input logic [31:0] fd, output int acc);
        int n;
        bus.req_valid    = 1'b1;
        bus.req_pc       = 32'h1000 + {24'd0, rob, 2'b00};
        bus.req_rob      = rob;
        bus.req_dest     = rob + 6'd10;
        bus.req_addr     = addr;
        bus.req_is_store = st;
        bus.req_byte     = byt;
        bus.req_wdata    = wd;
        bus.req_fwd      = fwd;
        bus.req_fwd_data = fd;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        acc = cyc;
        idle_req();
    endtask

    // Fetch the next response, bounded wait
    task automatic get(input string tag, output rec_t r);
        int n;
        n = 0;
        while (rq.size() == 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (rq.size() == 0) begin
            chk({tag, ".arrive"}, 32'(rq.size()), 32'd1);
            r.cyc = -1; r.pc = '0; r.rob = '0; r.dest = '0; r.data = '0; r.st = 1'b0; r.mis = 1'b0;
        end else begin
            r = rq.pop_front();
        end
    endtask

    task automatic chk_resp(input string tag, input rec_t r, input logic [5:0] rob,
                            input logic st, input logic [31:0] data, input logic mis);
        logic [5:0] edest;
        edest = st ? 6'd0 : rob + 6'd10;
        chk({tag, ".rob"},  32'(r.rob),  32'(rob));
        chk({tag, ".pc"},   r.pc,        32'h1000 + {24'd0, rob, 2'b00});
        chk({tag, ".dest"}, 32'(r.dest), 32'(edest));
        chk({tag, ".st"},   32'(r.st),   32'(st));
        chk({tag, ".data"}, r.data,      data);
        chk({tag, ".mis"},  32'(r.mis),  32'(mis));
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        rec_t r;
        int   a, b;
        int   acc [8];

        // Reset state
        idle_req();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst.resp_data",  bus.resp_data,       32'd0);
        chk("rst.resp_pc",    bus.resp_pc,         32'd0);
        chk("rst.resp_rob",   32'(bus.resp_rob),   32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("rst.req_ready",  32'(bus.req_ready),  32'd1);
        chk("rst.resp_valid2", 32'(bus.resp_valid), 32'd0);

        // 1: SW then LW same word; store at +3, load back-to-back at +6
        send(6'd1, 32'h100, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, a);
        send(6'd2, 32'h100, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0, b);
        get("t1.sw", r);
        chk("t1.sw_lat", 32'(r.cyc), 32'(a + 3));
        chk_resp("t1.sw", r, 6'd1, 1'b1, 32'h0, 1'b0);
        get("t1.lw", r);
        chk("t1.lw_lat", 32'(r.cyc), 32'(a + 6));
        chk_resp("t1.lw", r, 6'd2, 1'b0, 32'hDEADBEEF, 1'b0);

        // 2: byte store merge and sign-extended byte loads
        settle();
        send(6'd3, 32'h200, 1'b1, 1'b0, 32'h11223344, 1'b0, 32'h0, a);
        send(6'd4, 32'h203, 1'b1, 1'b1, 32'hAAAAAA80, 1'b0, 32'h0, a);
        send(6'd5, 32'h200, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0, a);
        send(6'd6, 32'h203, 1'b0, 1'b1, 32'h0,        1'b0, 32'h0, a);
        send(6'd7, 32'h201, 1'b0, 1'b1, 32'h0,        1'b0, 32'h0, a);
        get("t2.sw", r); chk_resp("t2.sw", r, 6'd3, 1'b1, 32'h0, 1'b0);
        get("t2.sb", r); chk_resp("t2.sb", r, 6'd4, 1'b1, 32'h0, 1'b0);
        get("t2.lw", r); chk_resp("t2.lw", r, 6'd5, 1'b0, 32'h80223344, 1'b0);
        get("t2.lb3", r); chk_resp("t2.lb3", r, 6'd6, 1'b0, 32'hFFFFFF80, 1'b0);
        get("t2.lb1", r); chk_resp("t2.lb1", r, 6'd7, 1'b0, 32'h00000033, 1'b0);

        // 3: forwarded load returns next cycle; fwd on a store is ignored
        settle();
        send(6'd5, 32'h300, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1234, a);
        get("t3.fwd", r);
        chk("t3.fwd_lat", 32'(r.cyc), 32'(a + 1));
        chk_resp("t3.fwd", r, 6'd5, 1'b0, 32'h1234, 1'b0);
        settle();
        send(6'd8, 32'h300, 1'b1, 1'b0, 32'hCAFEF00D, 1'b1, 32'h9999, a);
        send(6'd9, 32'h300, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,    b);
        get("t3.st", r);
        chk("t3.st_lat", 32'(r.cyc), 32'(a + 3));
        chk_resp("t3.st", r, 6'd8, 1'b1, 32'h0, 1'b0);
        get("t3.ld", r); chk_resp("t3.ld", r, 6'd9, 1'b0, 32'hCAFEF00D, 1'b0);

        // 4: continuous issue fills the FIFO; all respond in order
        settle();
        for (int k = 0; k < 8; k++) begin
            logic [5:0]  rob;
            logic [31:0] ad;
            rob = 6'd20 + 6'(k);
            ad  = 32'h400 + 32'((k / 2) * 4);
            send(rob, ad, (k % 2) == 0, 1'b0, 32'hA0000000 + 32'(k), 1'b0, 32'h0, acc[k]);
            if (k == 5) chk("t4.ready_full", 32'(bus.req_ready), 32'd0);
        end
        chk("t4.acc6_cons", 32'(acc[5]), 32'(acc[0] + 5));
        chk("t4.acc7_wait", 32'(acc[6]), 32'(acc[0] + 8));
        for (int k = 0; k < 8; k++) begin
            logic [5:0] rob;
            rob = 6'd20 + 6'(k);
            get("t4", r);
            if ((k % 2) == 0) chk_resp("t4.st", r, rob, 1'b1, 32'h0, 1'b0);
            else              chk_resp("t4.ld", r, rob, 1'b0, 32'hA0000000 + 32'(k - 1), 1'b0);
        end

        // 5: misaligned word load and address wrap
        send(6'd30, 32'h102,  1'b0, 1'b0, 32'h0, 1'b0, 32'h0, a);
        send(6'd31, 32'h1100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, a);
        get("t5.mis", r);  chk_resp("t5.mis", r, 6'd30, 1'b0, 32'hDEADBEEF, 1'b1);
        get("t5.wrap", r); chk_resp("t5.wrap", r, 6'd31, 1'b0, 32'hDEADBEEF, 1'b0);

        // 6: reset during a store access drops it and the queued load
        settle();
        send(6'd40, 32'h40, 1'b1, 1'b0, 32'h77, 1'b0, 32'h0, a);
        get("t6.pre", r); chk_resp("t6.pre", r, 6'd40, 1'b1, 32'h0, 1'b0);
        settle();
        send(6'd41, 32'h40, 1'b1, 1'b0, 32'h55, 1'b0, 32'h0, a);
        send(6'd42, 32'h40, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0, a);
        rstn = 1'b0;
        #1;
        chk("t6.rst_valid", 32'(bus.resp_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("t6.ready", 32'(bus.req_ready), 32'd1);
        settle();
        chk("t6.noresp", 32'(rq.size()), 32'd0);
        send(6'd43, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, a);
        get("t6.ld", r);
        chk("t6.ld_lat", 32'(r.cyc), 32'(a + 3));
        chk_resp("t6.ld", r, 6'd43, 1'b0, 32'h77, 1'b0);

        settle();
        chk("end.noextra", 32'(rq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
